// File: rtl/dl11_pkg.sv
// Shared definitions for the DL11 serial port: register offsets, CSR bit
// positions, UART state encoding and the default interrupt vectors.
package dl11_pkg;

    localparam logic [1:0] REG_RCSR = 2'd0;
    localparam logic [1:0] REG_RBUF = 2'd1;
    localparam logic [1:0] REG_XCSR = 2'd2;
    localparam logic [1:0] REG_XBUF = 2'd3;

    localparam int BIT_DONE  = 7;
    localparam int BIT_IE    = 6;
    localparam int BIT_MAINT = 2;
    localparam int BIT_ERR   = 15;
    localparam int BIT_OVR   = 14;
    localparam int BIT_FRM   = 13;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    localparam logic [15:0] VEC_RX = 16'o000060;
    localparam logic [15:0] VEC_TX = 16'o000064;

endpackage

// File: rtl/dl11_rx.sv
// DL11 receiver: synchronises the serial line, times the bits and assembles
// an 8N1 byte, reporting it with a one-clock done pulse and a framing flag.
module dl11_rx
    import dl11_pkg::*;
#(
    parameter int BAUD_DIV = 417
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       i_clear,
    input  logic       i_rxd,
    output logic [7:0] o_data,
    output logic       o_frm,
    output logic       o_donePulse
);

    localparam logic [15:0] LP_LAST = 16'(BAUD_DIV - 1);
    localparam logic [15:0] LP_HALF = 16'(BAUD_DIV / 2 - 1);

    logic        r_sync1, r_sync2, r_prev;
    uart_state_t r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift, r_data;
    logic        r_frm, r_done;

    // A start is recognised only on a falling edge, so a held-low break is one event
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else if (i_clear) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_frm   <= 1'b0;
            r_done  <= 1'b0;
        end else if (i_clear) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_frm   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_prev && !r_sync2) begin
                        r_state <= START;
                        r_cnt   <= '0;
                    end
                end
                START: begin
                    if (r_cnt == LP_HALF) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= r_sync2 ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (r_cnt == LP_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {r_sync2, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) r_state <= STOP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (r_cnt == LP_LAST) begin
                        r_cnt   <= '0;
                        r_data  <= r_shift;
                        r_frm   <= ~r_sync2;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_data      = r_data;
    assign o_frm       = r_frm;
    assign o_donePulse = r_done;

endmodule

// File: rtl/dl11_serial.sv
// DL11-compatible serial port: vm1 bus responder with RCSR/RBUF/XCSR/XBUF,
// a double-buffered 8N1 transmitter and vectored RX/TX interrupt requests.
module dl11_serial
    import dl11_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'o177560,
    parameter int          BAUD_DIV  = 417
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        bus_init,
    input  logic        ce_bus,
    input  logic [15:0] bus_addr,
    input  logic [15:0] bus_din,
    input  logic        bus_sync,
    input  logic        bus_we,
    input  logic [1:0]  bus_wtbt,
    input  logic        bus_stb,
    output logic [15:0] bus_dout,
    output logic        bus_ack,
    output logic        irq_rx_req,
    input  logic        irq_rx_ack,
    output logic        irq_tx_req,
    input  logic        irq_tx_ack,
    input  logic        uart_rxd,
    output logic        uart_txd
);

    localparam logic [15:0] LP_LAST = 16'(BAUD_DIV - 1);

    logic        w_access, w_accStart, w_wrLow, w_rbufRead, w_xbufWrite;
    logic [1:0]  w_idx;
    logic [15:0] w_rdData;
    logic        w_rxDone, w_rxFrm, w_rxLine, w_rxCond, w_txCond, w_unused;
    logic [7:0]  w_rxData;

    logic        r_accPrev, r_ack;
    logic        r_rxDone, r_rxIe, r_ovr, r_frm;
    logic [7:0]  r_rxData;
    logic        r_txReady, r_txIe, r_maint, r_txLine;
    logic [7:0]  r_hold, r_shift;
    uart_state_t r_txState;
    logic [15:0] r_txCnt;
    logic [2:0]  r_txBit;
    logic        r_rxCondPrev, r_txCondPrev, r_rxIrq, r_txIrq;

    assign w_idx       = bus_addr[2:1];
    assign w_access    = bus_sync & (bus_addr[15:3] == BASE_ADDR[15:3]) & bus_stb;
    assign w_accStart  = w_access & ~r_accPrev;
    assign w_wrLow     = w_accStart & bus_we & bus_wtbt[0];
    assign w_rbufRead  = w_accStart & ~bus_we & (w_idx == REG_RBUF);
    assign w_xbufWrite = w_wrLow & (w_idx == REG_XBUF) & r_txReady;
    assign w_rxLine    = r_maint ? r_txLine : uart_rxd;
    assign w_rxCond    = r_rxDone & r_rxIe;
    assign w_txCond    = r_txReady & r_txIe;
    assign w_unused    = ^{bus_addr[0], bus_din[15:8], bus_wtbt[1]};

    always_comb begin
        w_rdData = '0;
        if (w_access && !bus_we) begin
            case (w_idx)
                REG_RCSR: begin
                    w_rdData[BIT_DONE] = r_rxDone;
                    w_rdData[BIT_IE]   = r_rxIe;
                end
                REG_RBUF: begin
                    w_rdData[7:0]     = r_rxData;
                    w_rdData[BIT_ERR] = r_ovr | r_frm;
                    w_rdData[BIT_OVR] = r_ovr;
                    w_rdData[BIT_FRM] = r_frm;
                end
                REG_XCSR: begin
                    w_rdData[BIT_DONE]  = r_txReady;
                    w_rdData[BIT_IE]    = r_txIe;
                    w_rdData[BIT_MAINT] = r_maint;
                end
                default: w_rdData = '0;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_accPrev <= 1'b0;
            r_ack     <= 1'b0;
        end else if (bus_init) begin
            r_accPrev <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_accPrev <= w_access;
            if (ce_bus) r_ack <= w_access;
        end
    end

    // A completing byte outranks a simultaneous RBUF read so the new byte is never lost
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            {r_rxDone, r_rxIe, r_ovr, r_frm, r_txIe, r_maint} <= '0;
            r_rxData <= '0;
        end else if (bus_init) begin
            {r_rxDone, r_rxIe, r_ovr, r_frm, r_txIe, r_maint} <= '0;
            r_rxData <= '0;
        end else begin
            if (w_wrLow && w_idx == REG_RCSR) r_rxIe <= bus_din[BIT_IE];
            if (w_wrLow && w_idx == REG_XCSR) begin
                r_txIe  <= bus_din[BIT_IE];
                r_maint <= bus_din[BIT_MAINT];
            end
            if (w_rxDone) begin
                r_rxData <= w_rxData;
                r_frm    <= w_rxFrm;
                r_ovr    <= r_rxDone & ~w_rbufRead;
                r_rxDone <= 1'b1;
            end else if (w_rbufRead) begin
                r_rxDone <= 1'b0;
                r_ovr    <= 1'b0;
                r_frm    <= 1'b0;
            end
        end
    end

    // READY low means the holding register is full; the end of a stop bit reloads directly
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_txReady <= 1'b1;
            r_hold    <= '0;
            r_shift   <= '0;
            r_txState <= IDLE;
            r_txCnt   <= '0;
            r_txBit   <= '0;
            r_txLine  <= 1'b1;
        end else if (bus_init) begin
            r_txReady <= 1'b1;
            r_hold    <= '0;
            r_shift   <= '0;
            r_txState <= IDLE;
            r_txCnt   <= '0;
            r_txBit   <= '0;
            r_txLine  <= 1'b1;
        end else begin
            if (w_xbufWrite) begin
                r_hold    <= bus_din[7:0];
                r_txReady <= 1'b0;
            end
            case (r_txState)
                IDLE: begin
                    if (!r_txReady) begin
                        r_shift   <= r_hold;
                        r_txReady <= 1'b1;
                        r_txLine  <= 1'b0;
                        r_txCnt   <= '0;
                        r_txState <= START;
                    end
                end
                START: begin
                    if (r_txCnt == LP_LAST) begin
                        r_txCnt   <= '0;
                        r_txBit   <= '0;
                        r_txLine  <= r_shift[0];
                        r_txState <= DATA;
                    end else begin
                        r_txCnt <= r_txCnt + 16'd1;
                    end
                end
                DATA: begin
                    if (r_txCnt == LP_LAST) begin
                        r_txCnt <= '0;
                        if (r_txBit == 3'd7) begin
                            r_txLine  <= 1'b1;
                            r_txState <= STOP;
                        end else begin
                            r_txBit  <= r_txBit + 3'd1;
                            r_shift  <= {1'b0, r_shift[7:1]};
                            r_txLine <= r_shift[1];
                        end
                    end else begin
                        r_txCnt <= r_txCnt + 16'd1;
                    end
                end
                STOP: begin
                    if (r_txCnt == LP_LAST) begin
                        r_txCnt <= '0;
                        if (!r_txReady) begin
                            r_shift   <= r_hold;
                            r_txReady <= 1'b1;
                            r_txLine  <= 1'b0;
                            r_txState <= START;
                        end else begin
                            r_txState <= IDLE;
                        end
                    end else begin
                        r_txCnt <= r_txCnt + 16'd1;
                    end
                end
                default: r_txState <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            {r_rxCondPrev, r_txCondPrev, r_rxIrq, r_txIrq} <= '0;
        end else if (bus_init) begin
            {r_rxCondPrev, r_txCondPrev, r_rxIrq, r_txIrq} <= '0;
        end else begin
            r_rxCondPrev <= w_rxCond;
            r_txCondPrev <= w_txCond;
            if (w_rxCond && !r_rxCondPrev)                    r_rxIrq <= 1'b1;
            else if (irq_rx_ack || (!w_rxCond && r_rxCondPrev)) r_rxIrq <= 1'b0;
            if (w_txCond && !r_txCondPrev)                    r_txIrq <= 1'b1;
            else if (irq_tx_ack || (!w_txCond && r_txCondPrev)) r_txIrq <= 1'b0;
        end
    end

    dl11_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .i_clear     (bus_init),
        .i_rxd       (w_rxLine),
        .o_data      (w_rxData),
        .o_frm       (w_rxFrm),
        .o_donePulse (w_rxDone)
    );

    assign bus_dout   = w_rdData;
    assign bus_ack    = r_ack;
    assign irq_rx_req = r_rxIrq;
    assign irq_tx_req = r_txIrq;
    assign uart_txd   = r_txLine | r_maint;

endmodule

// File: tb/tb_dl11_serial.sv
// Directed bench for dl11_serial: bus reads/writes, TX bit timing, RX framing,
// overrun, interrupts, maintenance loopback and mid-frame reset.
module tb_dl11_serial;

    localparam int          BD   = 20;
    localparam logic [15:0] BASE = 16'o177560;
    localparam logic [15:0] A_RCSR = BASE;
    localparam logic [15:0] A_RBUF = BASE + 16'd2;
    localparam logic [15:0] A_XCSR = BASE + 16'd4;
    localparam logic [15:0] A_XBUF = BASE + 16'd6;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        bus_init = 1'b0;
    logic        ce_bus = 1'b1;
    logic [15:0] bus_addr = '0;
    logic [15:0] bus_din = '0;
    logic        bus_sync = 1'b0;
    logic        bus_we = 1'b0;
    logic [1:0]  bus_wtbt = 2'b00;
    logic        bus_stb = 1'b0;
    logic [15:0] bus_dout;
    logic        bus_ack;
    logic        irq_rx_req, irq_tx_req;
    logic        irq_rx_ack = 1'b0;
    logic        irq_tx_ack = 1'b0;
    logic        uart_rxd = 1'b1;
    logic        uart_txd;

    int nCompared = 0;
    int nMismatched = 0;
    int cycleCnt = 0;

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        int         startCycle;
    } txFrame_t;
    txFrame_t monQ[$];

    dl11_serial #(.BASE_ADDR(BASE), .BAUD_DIV(BD)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .bus_init(bus_init), .ce_bus(ce_bus),
        .bus_addr(bus_addr), .bus_din(bus_din), .bus_sync(bus_sync), .bus_we(bus_we),
        .bus_wtbt(bus_wtbt), .bus_stb(bus_stb), .bus_dout(bus_dout), .bus_ack(bus_ack),
        .irq_rx_req(irq_rx_req), .irq_rx_ack(irq_rx_ack),
        .irq_tx_req(irq_tx_req), .irq_tx_ack(irq_tx_ack),
        .uart_rxd(uart_rxd), .uart_txd(uart_txd)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cycleCnt <= cycleCnt + 1;

    // Independent 8N1 decoder on uart_txd, sampling mid-bit from the start edge
    always begin : txMonitor
        logic [7:0] monData;
        logic       monStop;
        int         monStart;
        @(negedge clk_sys);
        if (reset_n && uart_txd === 1'b0) begin
            monStart = cycleCnt;
            repeat (BD / 2) @(negedge clk_sys);
            for (int i = 0; i < 8; i++) begin
                repeat (BD) @(negedge clk_sys);
                monData[i] = uart_txd;
            end
            repeat (BD) @(negedge clk_sys);
            monStop = uart_txd;
            monQ.push_back('{monData, monStop, monStart});
        end
    end

    initial begin
        repeat (20000) @(posedge clk_sys);
        $display("[TB] FAIL watchdog: simulation exceeded %0d cycles, required completion", 20000);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic busWrite(input logic [15:0] addr, input logic [15:0] data, input logic [1:0] wtbt);
        bus_addr = addr; bus_din = data; bus_wtbt = wtbt;
        bus_we = 1'b1; bus_sync = 1'b1; bus_stb = 1'b1;
        @(negedge clk_sys);
        bus_stb = 1'b0; bus_sync = 1'b0; bus_we = 1'b0; bus_wtbt = 2'b00;
        @(negedge clk_sys);
    endtask

    task automatic busRead(input logic [15:0] addr, output logic [15:0] data);
        bus_addr = addr; bus_we = 1'b0; bus_sync = 1'b1; bus_stb = 1'b1;
        #1 data = bus_dout;
        @(negedge clk_sys);
        bus_stb = 1'b0; bus_sync = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic sendByte(input logic [7:0] data, input logic stopBit);
        uart_rxd = 1'b0;
        repeat (BD) @(negedge clk_sys);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = data[i];
            repeat (BD) @(negedge clk_sys);
        end
        uart_rxd = stopBit;
        repeat (BD) @(negedge clk_sys);
        uart_rxd = 1'b1;
        repeat (BD) @(negedge clk_sys);
    endtask

    task automatic test_reset;
        logic [15:0] rd;
        repeat (3) @(negedge clk_sys);
        nCompared++;
        if ({uart_txd, bus_ack, irq_rx_req, irq_tx_req} !== 4'b1000) begin
            nMismatched++;
            $display("[TB] FAIL reset_outputs: txd/ack/rxirq/txirq=%b required 1000",
                     {uart_txd, bus_ack, irq_rx_req, irq_tx_req});
        end
        nCompared++;
        if (bus_dout !== 16'h0000) begin
            nMismatched++; $display("[TB] FAIL reset_dout: got %h required 0000", bus_dout);
        end
        reset_n = 1'b1;
        @(negedge clk_sys);
        ce_bus = 1'b0;
        bus_addr = A_XCSR; bus_we = 1'b0; bus_sync = 1'b1; bus_stb = 1'b1;
        #1;
        nCompared++;
        if (bus_dout !== 16'o000200) begin
            nMismatched++; $display("[TB] FAIL xcsr_reset_read: got %o required 000200", bus_dout);
        end
        @(negedge clk_sys);
        nCompared++;
        if (bus_ack !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL ack_without_ce: got %b required 0", bus_ack);
        end
        ce_bus = 1'b1;
        @(negedge clk_sys);
        nCompared++;
        if (bus_ack !== 1'b1) begin
            nMismatched++; $display("[TB] FAIL ack_on_ce: got %b required 1", bus_ack);
        end
        bus_stb = 1'b0; bus_sync = 1'b0;
        @(negedge clk_sys);
        nCompared++;
        if (bus_ack !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL ack_release: got %b required 0", bus_ack);
        end
        busRead(A_RCSR, rd);
        nCompared++;
        if (rd !== 16'h0000) begin
            nMismatched++; $display("[TB] FAIL rcsr_reset_read: got %o required 0", rd);
        end
        busRead(A_RBUF, rd);
        nCompared++;
        if (rd !== 16'h0000) begin
            nMismatched++; $display("[TB] FAIL rbuf_reset_read: got %o required 0", rd);
        end
    endtask

    task automatic test_tx;
        logic [9:0]  expBits;
        logic [15:0] rd;
        int          waitCnt;
        int          badCnt;
        expBits = {1'b1, 8'h55, 1'b0};
        busWrite(A_XBUF, 16'h0055, 2'b01);
        waitCnt = 0;
        while (uart_txd !== 1'b0 && waitCnt < 4 * BD) begin
            @(negedge clk_sys);
            waitCnt++;
        end
        nCompared++;
        if (uart_txd !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL tx_start: uart_txd=%b required 0 within %0d clocks", uart_txd, 4 * BD);
        end else begin
            for (int b = 0; b < 10; b++) begin
                badCnt = 0;
                for (int c = 0; c < BD; c++) begin
                    if (uart_txd !== expBits[b]) badCnt++;
                    @(negedge clk_sys);
                end
                nCompared++;
                if (badCnt != 0) begin
                    nMismatched++;
                    $display("[TB] FAIL tx_bit%0d: %0d of %0d clocks differ, required level %b",
                             b, badCnt, BD, expBits[b]);
                end
            end
        end
        busRead(A_XCSR, rd);
        nCompared++;
        if (rd !== 16'o000200) begin
            nMismatched++; $display("[TB] FAIL tx_ready_after: got %o required 000200", rd);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] rd;
        logic [7:0]  d0, d1;
        int          gap;
        monQ.delete();
        busWrite(A_XBUF, 16'h0081, 2'b01);
        busWrite(A_XBUF, 16'h007E, 2'b01);
        busRead(A_XCSR, rd);
        nCompared++;
        if (rd !== 16'o000000) begin
            nMismatched++; $display("[TB] FAIL b2b_ready_low: got %o required 000000", rd);
        end
        busWrite(A_XBUF, 16'h00FF, 2'b01);
        repeat (35 * BD) @(negedge clk_sys);
        nCompared++;
        if (monQ.size() != 2) begin
            nMismatched++; $display("[TB] FAIL b2b_frame_count: got %0d required 2", monQ.size());
        end
        d0 = (monQ.size() > 0) ? monQ[0].data : 8'hxx;
        d1 = (monQ.size() > 1) ? monQ[1].data : 8'hxx;
        gap = (monQ.size() > 1) ? monQ[1].startCycle - monQ[0].startCycle : -1;
        nCompared++;
        if (d0 !== 8'h81 || d1 !== 8'h7E) begin
            nMismatched++; $display("[TB] FAIL b2b_data: got %h %h required 81 7e", d0, d1);
        end
        nCompared++;
        if (gap != 10 * BD) begin
            nMismatched++; $display("[TB] FAIL b2b_gap: start spacing %0d required %0d", gap, 10 * BD);
        end
    endtask

    task automatic test_rx;
        logic [15:0] rd;
        sendByte(8'hA3, 1'b1);
        busRead(A_RCSR, rd);
        nCompared++;
        if (rd !== 16'o000200) begin
            nMismatched++; $display("[TB] FAIL rx_done: RCSR got %o required 000200", rd);
        end
        busRead(A_RBUF, rd);
        nCompared++;
        if (rd !== 16'h00A3) begin
            nMismatched++; $display("[TB] FAIL rx_data: RBUF got %h required 00a3", rd);
        end
        busRead(A_RCSR, rd);
        nCompared++;
        if (rd !== 16'h0000) begin
            nMismatched++; $display("[TB] FAIL rx_done_clear: RCSR got %o required 0", rd);
        end
    endtask

    task automatic test_overrun;
        logic [15:0] rd;
        sendByte(8'h5A, 1'b1);
        sendByte(8'hC4, 1'b1);
        busRead(A_RBUF, rd);
        nCompared++;
        if (rd !== (16'o140000 | 16'h00C4)) begin
            nMismatched++; $display("[TB] FAIL rx_overrun: RBUF got %o required %o", rd, 16'o140000 | 16'h00C4);
        end
        busRead(A_RCSR, rd);
        nCompared++;
        if (rd !== 16'h0000) begin
            nMismatched++; $display("[TB] FAIL overrun_clear: RCSR got %o required 0", rd);
        end
    endtask

    task automatic test_framing;
        logic [15:0] rd;
        sendByte(8'h0F, 1'b0);
        busRead(A_RBUF, rd);
        nCompared++;
        if (rd !== 16'o120017) begin
            nMismatched++; $display("[TB] FAIL rx_framing: RBUF got %o required 120017", rd);
        end
        uart_rxd = 1'b0;
        repeat (BD * 3 / 10) @(negedge clk_sys);
        uart_rxd = 1'b1;
        repeat (3 * BD) @(negedge clk_sys);
        busRead(A_RCSR, rd);
        nCompared++;
        if (rd !== 16'h0000) begin
            nMismatched++; $display("[TB] FAIL rx_glitch: RCSR got %o required 0", rd);
        end
        busRead(A_RBUF, rd);
        nCompared++;
        if (rd !== 16'h000F) begin
            nMismatched++; $display("[TB] FAIL rx_flags_cleared: RBUF got %o required 000017", rd);
        end
    endtask

    task automatic test_irq;
        logic [15:0] rd;
        busWrite(A_RCSR, 16'o000100, 2'b11);
        nCompared++;
        if (irq_rx_req !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL rx_irq_idle: got %b required 0", irq_rx_req);
        end
        sendByte(8'h12, 1'b1);
        nCompared++;
        if (irq_rx_req !== 1'b1) begin
            nMismatched++; $display("[TB] FAIL rx_irq_set: got %b required 1", irq_rx_req);
        end
        irq_rx_ack = 1'b1;
        @(negedge clk_sys);
        irq_rx_ack = 1'b0;
        @(negedge clk_sys);
        nCompared++;
        if (irq_rx_req !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL rx_irq_ack: got %b required 0", irq_rx_req);
        end
        busRead(A_RBUF, rd);
        busWrite(A_RCSR, 16'h0000, 2'b11);
        nCompared++;
        if (irq_tx_req !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL tx_irq_idle: got %b required 0", irq_tx_req);
        end
        busWrite(A_XCSR, 16'o000100, 2'b11);
        nCompared++;
        if (irq_tx_req !== 1'b1) begin
            nMismatched++; $display("[TB] FAIL tx_irq_set: got %b required 1", irq_tx_req);
        end
        irq_tx_ack = 1'b1;
        @(negedge clk_sys);
        irq_tx_ack = 1'b0;
        @(negedge clk_sys);
        nCompared++;
        if (irq_tx_req !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL tx_irq_ack: got %b required 0", irq_tx_req);
        end
        busWrite(A_XCSR, 16'h0000, 2'b11);
    endtask

    task automatic test_byte_lanes;
        logic [15:0] rd;
        busWrite(A_XCSR, 16'o000104, 2'b10);
        busRead(A_XCSR, rd);
        nCompared++;
        if (rd !== 16'o000200) begin
            nMismatched++; $display("[TB] FAIL lane_high_only: XCSR got %o required 000200", rd);
        end
        busWrite(A_XCSR, 16'o000104, 2'b00);
        busRead(A_XCSR, rd);
        nCompared++;
        if (rd !== 16'o000200) begin
            nMismatched++; $display("[TB] FAIL lane_none: XCSR got %o required 000200", rd);
        end
        busWrite(A_XCSR, 16'o000004, 2'b01);
        busRead(A_XCSR, rd);
        nCompared++;
        if (rd !== 16'o000204) begin
            nMismatched++; $display("[TB] FAIL lane_low: XCSR got %o required 000204", rd);
        end
        busWrite(A_XCSR, 16'h0000, 2'b11);
    endtask

    task automatic test_maint;
        logic [15:0] rd;
        int          lowCnt;
        busWrite(A_XCSR, 16'o000004, 2'b01);
        busWrite(A_XBUF, 16'h003C, 2'b01);
        lowCnt = 0;
        repeat (11 * BD) begin
            @(negedge clk_sys);
            if (uart_txd !== 1'b1) lowCnt++;
        end
        nCompared++;
        if (lowCnt != 0) begin
            nMismatched++; $display("[TB] FAIL maint_txd_high: %0d low clocks, required 0", lowCnt);
        end
        busRead(A_RCSR, rd);
        nCompared++;
        if (rd !== 16'o000200) begin
            nMismatched++; $display("[TB] FAIL maint_done: RCSR got %o required 000200", rd);
        end
        busRead(A_RBUF, rd);
        nCompared++;
        if (rd !== 16'h003C) begin
            nMismatched++; $display("[TB] FAIL maint_loopback: RBUF got %h required 003c", rd);
        end
        busWrite(A_XCSR, 16'h0000, 2'b11);
    endtask

    task automatic test_reset_midframe;
        logic [15:0] rd;
        int          lowCnt;
        busWrite(A_RCSR, 16'o000100, 2'b11);
        sendByte(8'h99, 1'b1);
        busWrite(A_XBUF, 16'h0000, 2'b01);
        busWrite(A_XBUF, 16'h00AA, 2'b01);
        repeat (3 * BD) @(negedge clk_sys);
        nCompared++;
        if (uart_txd !== 1'b0 || irq_rx_req !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL pre_reset: txd=%b rxirq=%b required txd=0 rxirq=1", uart_txd, irq_rx_req);
        end
        reset_n = 1'b0;
        #1;
        nCompared++;
        if ({uart_txd, bus_ack, irq_rx_req, irq_tx_req} !== 4'b1000 || bus_dout !== 16'h0000) begin
            nMismatched++;
            $display("[TB] FAIL midframe_reset: txd/ack/rxirq/txirq=%b dout=%h required 1000 and 0000",
                     {uart_txd, bus_ack, irq_rx_req, irq_tx_req}, bus_dout);
        end
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);
        busRead(A_XCSR, rd);
        nCompared++;
        if (rd !== 16'o000200) begin
            nMismatched++; $display("[TB] FAIL reset_ready: XCSR got %o required 000200", rd);
        end
        lowCnt = 0;
        repeat (12 * BD) begin
            @(negedge clk_sys);
            if (uart_txd !== 1'b1) lowCnt++;
        end
        nCompared++;
        if (lowCnt != 0) begin
            nMismatched++; $display("[TB] FAIL holding_emptied: %0d low clocks, required 0", lowCnt);
        end
        busRead(A_RCSR, rd);
        nCompared++;
        if (rd !== 16'h0000) begin
            nMismatched++; $display("[TB] FAIL reset_rcsr: got %o required 0", rd);
        end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_back_to_back();
        test_rx();
        test_overrun();
        test_framing();
        test_irq();
        test_byte_lanes();
        test_maint();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
